branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side companion to the execute-stage branch comparator. It predicts conditional-branch direction at fetch from a table of 2-bit saturating counters indexed by PC. It is trained one cycle later by the resolved outcome coming back from execute, and it counts mispredictions. It sits between the PC-select logic (lookup port) and the execute stage (update port).

## Interface
- IDX_BITS, 6: table index width; 2^IDX_BITS entries, index = PC[IDX_BITS+1:2].
- TAG_BITS, 8: BTB tag width, tag = PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. Used only with RV_BTB_EN.
- iCLK input 1: clock; all state updates on rising edge.
- iRSTn input 1: asynchronous, active-low reset.
- iPC input 32: fetch PC to predict.
- oPredTaken output 1: predicted taken (combinational from state and iPC).
- oPredTarget output 32: predicted target. Zero when the RV_BTB_EN feature is compiled out.
- iUpdValid input 1: resolved conditional branch present this cycle.
- iUpdPC input 32: PC of the resolved branch.
- iUpdTaken input 1: actual outcome (comparator result).
- iUpdPredTaken input 1: prediction that had been made for this branch.
- iUpdTarget input 32: actual computed target.
- oMispredict output 1: iUpdValid && (iUpdTaken != iUpdPredTaken). Combinational.
- oMispredCount output 16: registered saturating misprediction count.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when counter[1]=1.
- Reset (iRSTn=0, asynchronous) sets:
  - every counter to 01;
  - every BTB valid bit to 0;
  - oMispredCount to 0.
  - Consequence: oPredTaken=0 and oPredTarget=0 immediately after reset.
- Update on an edge with iUpdValid=1 at index u:
  - taken: counter = min(counter+1, 3);
  - not taken: counter = max(counter−1, 0).
  - Saturation is never allowed to wrap.
- iUpdValid=0: no state changes.
- Mispredict counter: increments by 1 on each edge where oMispredict=1. It holds at 16'hFFFF and does not wrap.
- Lookup and update in the same cycle at the same index: lookup returns the pre-update value. There is no bypass.
- Updates with X/garbage PC bits above the index affect only the indexed entry. Aliasing between branches is accepted.

## Timing
- Lookup latency: 0 cycles. Outputs settle in the same cycle as iPC.
- Update visibility: the new counter/BTB contents are seen by a lookup in the cycle after the updating edge.
- oMispredict is valid in the same cycle as iUpdValid.
- oMispredCount reflects the event one edge after it.
- Reset asserted mid-operation discards any in-flight update in that cycle. Deassertion is taken synchronously to iCLK by the surrounding reset synchronizer.
- Throughput: one lookup and one update per cycle, sustained.

## Configuration
- RV_BTB_EN defined: add a direct-mapped BTB of 2^IDX_BITS entries. Each entry holds {valid, tag, target[31:0]}.
  - oPredTaken = BTB valid && tag match && counter[1]; oPredTarget = stored target on hit, else 0.
  - On an update with iUpdTaken=1, write valid=1, tag, and iUpdTarget.
  - Not-taken updates leave the BTB entry unchanged.
  - Counters update exactly as in Operation, regardless of BTB hit.
- RV_BTB_EN undefined: no BTB storage.
  - oPredTaken = counter[1]; oPredTarget tied to 32'h0. The fetch stage computes the target itself.
  - TAG_BITS is unused.

## Test plan
- Reset → any iPC gives oPredTaken=0; oMispredCount=0. With BTB, oPredTarget=0.
- Three updates for PC 0x100, taken (taken, taken, taken) → counter goes 01→10→11→11. The lookup of 0x100 is taken after the first update. Two not-taken updates then give 11→10→01 → predicts not-taken.
- Same-cycle update (taken) of 0x100 and lookup of 0x100 from 01 → lookup shows 0 that cycle and 1 the next.
- Mispredict counter:
  - iUpdTaken=1, iUpdPredTaken=0 for 5 cycles → oMispredict=1 each cycle; oMispredCount=5.
  - Force 70000 mismatches → count saturates at 0xFFFF.
- RV_BTB_EN, IDX_BITS=6:
  - Train 0x100 taken twice with target 0x200 → lookup 0x100 gives oPredTaken=1, oPredTarget=0x200.
  - Lookup 0x4100 (same index, different tag) → oPredTaken=0, oPredTarget=0.
- Assert iRSTn low mid-stream while iUpdValid=1 → all counters are 01, the count is 0, and no update is retained.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Fetch-side 2-bit saturating-counter direction predictor with
//             execute-side training and a saturating misprediction counter.
//             Optional direct-mapped BTB enabled by defining RV_BTB_EN.
//  Revision : 1.0 - initial release
// ============================================================================

module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic [31:0] iPC,
    output logic        oPredTaken,
    output logic [31:0] oPredTarget,
    input  logic        iUpdValid,
    input  logic [31:0] iUpdPC,
    input  logic        iUpdTaken,
    input  logic        iUpdPredTaken,
    input  logic [31:0] iUpdTarget,
    output logic        oMispredict,
    output logic [15:0] oMispredCount
);

    localparam int          c_entries  = 1 << IDX_BITS;
    localparam logic [1:0]  c_ctr_init = 2'b01;
    localparam logic [1:0]  c_ctr_max  = 2'b11;
    localparam logic [1:0]  c_ctr_min  = 2'b00;
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;
    localparam logic [31:0] c_tag_bits = TAG_BITS;

    logic [IDX_BITS-1:0] w_lkp_idx;
    logic [IDX_BITS-1:0] w_upd_idx;
    logic [1:0]          w_lkp_ctr;
    logic [1:0]          w_upd_ctr;
    logic [1:0]          w_upd_ctr_next;
    logic                w_mispredict;

    logic [1:0]          r_ctr [c_entries];
    logic [15:0]         r_mis_cnt;

    assign w_lkp_idx = iPC[IDX_BITS+1:2];
    assign w_upd_idx = iUpdPC[IDX_BITS+1:2];
    assign w_lkp_ctr = r_ctr[w_lkp_idx];
    assign w_upd_ctr = r_ctr[w_upd_idx];

    // Saturating step: never wraps past strong-taken or strong-not-taken.
    always_comb begin
        w_upd_ctr_next = w_upd_ctr;
        if (iUpdTaken) begin
            if (w_upd_ctr != c_ctr_max) begin
                w_upd_ctr_next = w_upd_ctr + 2'b01;
            end
        end else begin
            if (w_upd_ctr != c_ctr_min) begin
                w_upd_ctr_next = w_upd_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            for (int i = 0; i < c_entries; i++) begin
                r_ctr[i] <= c_ctr_init;
            end
        end else if (iUpdValid) begin
            r_ctr[w_upd_idx] <= w_upd_ctr_next;
        end
    end

    assign w_mispredict = iUpdValid && (iUpdTaken != iUpdPredTaken);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_mis_cnt <= 16'h0000;
        end else if (w_mispredict && (r_mis_cnt != c_cnt_max)) begin
            r_mis_cnt <= r_mis_cnt + 16'h0001;
        end
    end

    assign oMispredict   = w_mispredict;
    assign oMispredCount = r_mis_cnt;

`ifdef RV_BTB_EN
    logic [TAG_BITS-1:0] w_lkp_tag;
    logic [TAG_BITS-1:0] w_upd_tag;
    logic                w_btb_hit;

    logic [c_entries-1:0] r_btb_valid;
    logic [TAG_BITS-1:0]  r_btb_tag [c_entries];
    logic [31:0]          r_btb_tgt [c_entries];

    assign w_lkp_tag = iPC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_upd_tag = iUpdPC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_btb_valid <= '0;
        end else if (iUpdValid && iUpdTaken) begin
            r_btb_valid[w_upd_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: a cleared valid bit masks them.
    always_ff @(posedge iCLK) begin
        if (iRSTn && iUpdValid && iUpdTaken) begin
            r_btb_tag[w_upd_idx] <= w_upd_tag;
            r_btb_tgt[w_upd_idx] <= iUpdTarget;
        end
    end

    assign w_btb_hit   = r_btb_valid[w_lkp_idx] && (r_btb_tag[w_lkp_idx] == w_lkp_tag);
    assign oPredTaken  = w_btb_hit && w_lkp_ctr[1];
    assign oPredTarget = w_btb_hit ? r_btb_tgt[w_lkp_idx] : 32'h0000_0000;
`else
    assign oPredTaken  = w_lkp_ctr[1];
    assign oPredTarget = 32'h0000_0000;
`endif

    // Bits outside the index/tag fields are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{iPC, iUpdPC, iUpdTarget, c_tag_bits};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Purpose  : Directed, table-driven self-checking bench for branch_predictor.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_branch_predictor;

`ifdef RV_BTB_EN
    localparam bit c_btb = 1'b1;
`else
    localparam bit c_btb = 1'b0;
`endif

    logic        iCLK;
    logic        iRSTn;
    logic [31:0] iPC;
    logic        oPredTaken;
    logic [31:0] oPredTarget;
    logic        iUpdValid;
    logic [31:0] iUpdPC;
    logic        iUpdTaken;
    logic        iUpdPredTaken;
    logic [31:0] iUpdTarget;
    logic        oMispredict;
    logic [15:0] oMispredCount;

    int n_pass;
    int n_total;

    branch_predictor #(.IDX_BITS(6), .TAG_BITS(8)) dut (
        .iCLK          (iCLK),
        .iRSTn         (iRSTn),
        .iPC           (iPC),
        .oPredTaken    (oPredTaken),
        .oPredTarget   (oPredTarget),
        .iUpdValid     (iUpdValid),
        .iUpdPC        (iUpdPC),
        .iUpdTaken     (iUpdTaken),
        .iUpdPredTaken (iUpdPredTaken),
        .iUpdTarget    (iUpdTarget),
        .oMispredict   (oMispredict),
        .oMispredCount (oMispredCount)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        up;
        logic [31:0] utgt;
        logic [31:0] lpc;
        logic        epred;
        logic [31:0] etgt;   // expected target when the BTB is built in
        logic        emis;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle_upd();
        iUpdValid     = 1'b0;
        iUpdPC        = 32'h0;
        iUpdTaken     = 1'b0;
        iUpdPredTaken = 1'b0;
        iUpdTarget    = 32'h0;
    endtask

    task automatic do_reset();
        idle_upd();
        iRSTn = 1'b0;
        tick();
        tick();
        iRSTn = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic p, input logic [31:0] tgt);
        iUpdValid     = 1'b1;
        iUpdPC        = pc;
        iUpdTaken     = t;
        iUpdPredTaken = p;
        iUpdTarget    = tgt;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        iPC     = 32'h100;
        iRSTn   = 1'b1;
        idle_upd();

        //            uv    upc             ut    up    utgt         lpc          ep    etgt         em
        vecs[0]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h200, 32'h0000_0100, 1'b0, 32'h000, 1'b1};
        vecs[1]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h200, 32'h0000_0100, 1'b1, 32'h200, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h200, 32'h0000_0100, 1'b1, 32'h200, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h000, 32'h0000_0100, 1'b1, 32'h200, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h999, 32'h0000_0100, 1'b1, 32'h200, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h999, 32'h0000_0100, 1'b1, 32'h200, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'h000, 32'h0000_0100, 1'b0, 32'h200, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h000, 32'h0000_0100, 1'b0, 32'h200, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h000, 32'h0000_0100, 1'b0, 32'h200, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h240, 32'h0000_0100, 1'b0, 32'h200, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'h000, 32'h0000_0100, 1'b0, 32'h240, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h300, 32'h0000_0104, 1'b0, 32'h000, 1'b1};
        vecs[12] = '{1'b1, 32'hFFFF_0104, 1'b1, 1'b1, 32'h500, 32'h0000_0104, 1'b1, 32'h300, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h000, 32'h0000_0104, 1'b1, 32'h500, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h000, 32'h0000_0100, 1'b0, 32'h240, 1'b0};

        // Reset state
        do_reset();
        iPC = 32'h100;
        #1;
        chk("rst pred 0x100", {31'b0, oPredTaken}, 32'h0);
        chk("rst tgt 0x100", oPredTarget, 32'h0);
        iPC = 32'h4104;
        #1;
        chk("rst pred 0x4104", {31'b0, oPredTaken}, 32'h0);
        chk("rst count", {16'b0, oMispredCount}, 32'h0);
        chk("rst mispredict", {31'b0, oMispredict}, 32'h0);

        // Table-driven training / lookup sequence
        for (int i = 0; i < 15; i++) begin
            iUpdValid     = vecs[i].uv;
            iUpdPC        = vecs[i].upc;
            iUpdTaken     = vecs[i].ut;
            iUpdPredTaken = vecs[i].up;
            iUpdTarget    = vecs[i].utgt;
            iPC           = vecs[i].lpc;
            @(negedge iCLK);
            chk($sformatf("vec%0d pred", i), {31'b0, oPredTaken}, {31'b0, vecs[i].epred});
            chk($sformatf("vec%0d target", i), oPredTarget, c_btb ? vecs[i].etgt : 32'h0);
            chk($sformatf("vec%0d mispredict", i), {31'b0, oMispredict}, {31'b0, vecs[i].emis});
            tick();
        end
        idle_upd();
        #1;
        chk("table mispredict count", {16'b0, oMispredCount}, 32'd5);

        // Five consecutive mispredictions, then saturation
        do_reset();
        upd(32'h108, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            chk($sformatf("burst%0d mispredict", i), {31'b0, oMispredict}, 32'h1);
            tick();
        end
        idle_upd();
        #1;
        chk("burst count", {16'b0, oMispredCount}, 32'd5);
        upd(32'h108, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        @(negedge iCLK);
        chk("saturated count", {16'b0, oMispredCount}, 32'h0000_FFFF);
        chk("saturated mispredict", {31'b0, oMispredict}, 32'h1);
        tick();
        chk("count holds", {16'b0, oMispredCount}, 32'h0000_FFFF);
        idle_upd();

        // BTB tag check: same index, different tag
        do_reset();
        upd(32'h100, 1'b1, 1'b1, 32'h200);
        tick();
        tick();
        idle_upd();
        iPC = 32'h100;
        #1;
        chk("trained pred 0x100", {31'b0, oPredTaken}, 32'h1);
        chk("trained tgt 0x100", oPredTarget, c_btb ? 32'h200 : 32'h0);
        iPC = 32'h4100;
        #1;
        chk("alias pred 0x4100", {31'b0, oPredTaken}, c_btb ? 32'h0 : 32'h1);
        chk("alias tgt 0x4100", oPredTarget, 32'h0);

        // Reset asserted mid-cycle with an update in flight
        do_reset();
        upd(32'h100, 1'b1, 1'b0, 32'h200);
        tick();
        tick();
        upd(32'h108, 1'b1, 1'b0, 32'h700);
        iPC = 32'h100;
        #1;
        chk("pre-rst pred", {31'b0, oPredTaken}, 32'h1);
        chk("pre-rst count", {16'b0, oMispredCount}, 32'd2);
        #1;
        iRSTn = 1'b0;
        #1;
        chk("async rst pred", {31'b0, oPredTaken}, 32'h0);
        chk("async rst count", {16'b0, oMispredCount}, 32'h0);
        tick();
        iRSTn = 1'b1;
        idle_upd();
        iPC = 32'h108;
        #1;
        chk("dropped upd pred", {31'b0, oPredTaken}, 32'h0);
        chk("dropped upd tgt", oPredTarget, 32'h0);
        chk("post-rst count", {16'b0, oMispredCount}, 32'h0);
        upd(32'h100, 1'b1, 1'b1, 32'h200);
        tick();
        idle_upd();
        iPC = 32'h100;
        #1;
        chk("post-rst weakNT->weakT", {31'b0, oPredTaken}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
